// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the memory responder
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_ERR} rdata_src_t;
  localparam int WORD_BYTES = 4;
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int depth);
    return (addr >> $clog2(WORD_BYTES)) & 32'(depth - 1);
  endfunction
endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port word RAM with synchronous, enabled read
module sp_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] a,
  input  logic [31:0]   d,
  output logic [31:0]   q
);
  logic [31:0] mem [DEPTH];
  // write on we, capture read data only on re so q holds between reads
  always_ff @(posedge clk) begin
    if (we) mem[a] <= d;
    if (re) q <= mem[a];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated word memory with ready handshake for the multicycle control unit
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ERR_DATA    = 32'h0000_0000
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        fault,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  mem_state_t  state;
  rdata_src_t  src;
  logic [CW-1:0] cnt;
  logic [31:0] lat_addr, lat_wdata, acc_addr, acc_wdata, ram_d, ram_q;
  logic        lat_write, lat_bad, acc_write, acc_bad;
  logic        accept, init_wr, access, ram_we, ram_re;
  logic [AW-1:0] ram_a;
  // zero wait states access on the accepting edge with live inputs; otherwise the latched request is used
  always_comb begin
    accept    = state == IDLE && clk_en && (mem_read || mem_write) && !init_we;
    init_wr   = state == IDLE && init_we;
    access    = (WAIT_STATES == 0) ? accept : (clk_en && state == WAIT && cnt == CW'(1));
    acc_addr  = state == IDLE ? addr : lat_addr;
    acc_wdata = state == IDLE ? wdata : lat_wdata;
    acc_write = state == IDLE ? mem_write : lat_write;
    acc_bad   = state == IDLE ? (addr[1:0] != 2'b00 || (mem_read && mem_write)) : lat_bad;
    ram_we    = !rst && (init_wr || (access && acc_write && !acc_bad));
    ram_re    = !rst && access && !acc_write && !acc_bad;
    ram_a     = init_wr ? AW'(word_index(init_addr, DEPTH_WORDS)) : AW'(word_index(acc_addr, DEPTH_WORDS));
    ram_d     = init_wr ? init_data : acc_wdata;
    rdata     = src == SRC_RAM ? ram_q : src == SRC_ERR ? ERR_DATA : 32'h0;
  end
  // protocol FSM: accept, count wait states, hold ready for one tick
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      src       <= SRC_ZERO;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      fault     <= 1'b0;
    end else if (clk_en) begin
      if (access) begin
        src <= acc_bad ? SRC_ERR : acc_write ? src : SRC_RAM;
        if (acc_bad) fault <= 1'b1;
      end
      if (accept) begin
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_write <= mem_write;
        lat_bad   <= addr[1:0] != 2'b00 || (mem_read && mem_write);
        cnt       <= CW'(WAIT_STATES);
        state     <= (WAIT_STATES == 0) ? RESP : WAIT;
        mem_ready <= WAIT_STATES == 0;
        mem_busy  <= 1'b1;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state     <= RESP;
          mem_ready <= 1'b1;
        end
      end else if (state == RESP) begin
        state     <= IDLE;
        mem_ready <= 1'b0;
        mem_busy  <= 1'b0;
      end
    end
  end
  sp_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk(clk_100M),
    .we (ram_we),
    .re (ram_re),
    .a  (ram_a),
    .d  (ram_d),
    .q  (ram_q)
  );
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle MIPS control unit.
- Services the control unit's MemRead/MemWrite strobes on the shared word memory (instruction and data, selected upstream by the IorD mux).
- Inserts a configurable number of wait states and returns a ready handshake so the FSM can stall.
- Runs on the 100 MHz clock and advances only on clk_en ticks from clk_divider.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥ 4.
- WAIT_STATES, 2, clk_en ticks between request acceptance and the access; 0 is legal.
- ERR_DATA, 32'h0000_0000, rdata value returned on a faulted access.

Ports:
- clk_100M  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  one-cycle enable pulse from clk_divider; all protocol state advances only when high.
- mem_read  in  1  read request from the control unit.
- mem_write  in  1  write request from the control unit.
- addr  in  32  byte address (post-IorD mux).
- wdata  in  32  write data (register B).
- rdata  out  32  read data to the IR/MDR.
- mem_ready  out  1  access complete; control unit may advance.
- mem_busy  out  1  request in flight (state != IDLE).
- fault  out  1  sticky; set on misaligned access or simultaneous read+write.
- init_we  in  1  bench/boot load strobe.
- init_addr  in  32  load byte address.
- init_data  in  32  load data.

Behaviour:
- Reset: state IDLE, rdata=0, mem_ready=0, mem_busy=0, fault=0, wait counter=0. RAM contents are not cleared. Reset mid-transaction aborts it and performs no write.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Addresses beyond DEPTH wrap modulo DEPTH.
- States: IDLE, WAIT, RESP.
- IDLE, on a clk_en tick with mem_read|mem_write and no init_we: latch addr, wdata and op.
  - If WAIT_STATES=0, perform the access on that edge and go to RESP.
  - Otherwise load counter=WAIT_STATES and go to WAIT.
- WAIT: on each clk_en tick, decrement the counter. On the tick where the counter reaches 0, perform the access and go to RESP.
  - Request lines are ignored in WAIT; a dropped request still completes.
- RESP: mem_ready=1 continuously. On the next clk_en tick, return to IDLE and clear mem_ready. A request present on that tick is not accepted; it is accepted on the following tick.
- Latency: request accepted at tick k → access at tick k+WAIT_STATES → mem_ready high from the next clk_100M cycle until tick k+WAIT_STATES+1.
- Read: rdata ← RAM[index], registered at the access edge. rdata holds until the next read, fault, or reset. Writes do not change rdata.
- Write: RAM[index] ← latched wdata at the access edge.
- Faults:
  - Conditions: latched addr[1:0]≠0, or mem_read and mem_write both high at acceptance.
  - Effect: no RAM write, rdata=ERR_DATA, fault set (sticky until rst). mem_ready handshake proceeds normally so the FSM never deadlocks.
- init_we: honoured only in IDLE, on any clk_100M cycle regardless of clk_en. Writes RAM[init index] ← init_data, with wrap and no alignment check (addr[1:0] ignored).
  - In IDLE, init_we takes priority over request acceptance on the same cycle.
  - Ignored in WAIT and RESP.
- clk_en low: state, counter and outputs hold.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] mem_state_t {IDLE, WAIT, RESP};
  - localparam WORD_BYTES=4;
  - function word_index(addr, depth).
- One sub-module, sp_ram: single write port, synchronous read, DEPTH_WORDS×32.
  - mem_responder muxes the write port between the init path and the access path; the two are mutually exclusive by state and priority.

Test Plan:
- Preload RAM[3]=32'hCAFE_0001 via init; WAIT_STATES=2; mem_read with addr=0x0C at tick k → mem_ready rises after tick k+2, rdata=32'hCAFE_0001, ready low after tick k+3, fault=0.
- mem_write with addr=0x10, wdata=32'h1234_5678, then a read of 0x10 → rdata=32'h1234_5678. Repeat with addr=0x410 (DEPTH 256) → aliases word 4, same data.
- WAIT_STATES=0: read accepted at tick k → mem_ready high after tick k, low after tick k+1. Back-to-back held request → second acceptance at tick k+2.
- Misaligned read addr=0x0D → rdata=ERR_DATA, mem_ready handshake completes, fault=1 and stays set through later good accesses until rst.
- Assert rst during WAIT of a write to 0x20 holding 32'hAAAA_AAAA → state IDLE, mem_ready=0, and a later read of 0x20 returns the pre-reset value.
- mem_read+mem_write together → no write, fault=1. init_we asserted in IDLE on the same cycle as a request → init write lands, request accepted on the next clk_en tick.
